// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the serial pattern scanner: FSM state encoding,
// default widths and the configuration-length legality rule.
package pattern_scan_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int LEN_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Bundle of configuration, scan-control, serial-data and result signals of the
// pattern scanner; master drives requests and data, slave is the scanner.
interface pattern_scan_ctrl_if
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               start;
  logic [CNT_W-1:0]   frame_len;
  logic               abort;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic               busy;
  logic               match;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic [CNT_W-1:0]   first_pos;
  logic               found;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len, abort,
           bit_in, bit_valid,
    input  bit_ready, busy, match, done, match_count, first_pos, found, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len, abort,
           bit_in, bit_valid,
    output bit_ready, busy, match, done, match_count, first_pos, found, cfg_err
  );
endinterface

// File: rtl/pattern_matcher.sv
// Shift history, saturating fill counter and length-masked comparator; hit is
// combinational for the bit being shifted in this cycle.
module pattern_matcher
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);
  localparam int FILL_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist_reg;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [FILL_W-1:0]  fill_reg;
  logic [FILL_W-1:0]  fill_next;

  // Only the newest len history bits take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (gi < int'(len));
    end
  endgenerate

  always_comb begin
    hist_next = {hist_reg[MAX_LEN-2:0], bit_in};
    fill_next = (int'(fill_reg) == MAX_LEN) ? fill_reg : fill_reg + FILL_W'(1);
    hit       = shift && (int'(fill_next) >= int'(len))
                && (((hist_next ^ pattern) & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (shift) begin
      hist_reg <= hist_next;
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      fill_reg <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: control FSM, configuration registers and result
// counters around a pattern_matcher instance.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  pattern_scan_ctrl_if.slave  bus
);
  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               cfg_err_reg;
  logic [CNT_W-1:0]   frame_len_reg;
  logic [CNT_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   first_pos_reg;
  logic               found_reg;
  logic               match_reg;
  logic               start_ok;
  logic               consume;
  logic               last_bit;
  logic               hit;

  assign start_ok = (state_reg == ST_IDLE) && bus.start;
  // Abort wins over a bit offered in the same cycle.
  assign consume  = (state_reg == ST_SCAN) && bus.bit_valid && !bus.abort;
  assign last_bit = consume && (idx_reg == frame_len_reg - CNT_W'(1));

  pattern_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .shift   (consume),
    .bit_in  (bus.bit_in),
    .pattern (pattern_reg),
    .len     (len_reg),
    .overlap (overlap_reg),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = (bus.frame_len != '0) ? ST_SCAN : ST_DONE;
      ST_SCAN: if (bus.abort || last_bit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_reg == ST_SCAN);
    bus.bit_ready   = (state_reg == ST_SCAN);
    bus.done        = (state_reg == ST_DONE);
    bus.match       = match_reg;
    bus.match_count = count_reg;
    bus.first_pos   = first_pos_reg;
    bus.found       = found_reg;
    bus.cfg_err     = cfg_err_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg <= '0;
      len_reg     <= LEN_W'(1);
      overlap_reg <= 1'b1;
      cfg_err_reg <= 1'b0;
    end else if (bus.cfg_we && state_reg != ST_SCAN) begin
      if (len_legal(bus.cfg_len, MAX_LEN)) begin
        pattern_reg <= bus.cfg_pattern;
        len_reg     <= bus.cfg_len;
        overlap_reg <= bus.cfg_overlap;
        cfg_err_reg <= 1'b0;
      end else begin
        cfg_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_len_reg <= '0;
      idx_reg       <= '0;
      count_reg     <= '0;
      first_pos_reg <= '0;
      found_reg     <= 1'b0;
      match_reg     <= 1'b0;
    end else begin
      match_reg <= hit;
      if (start_ok) begin
        frame_len_reg <= bus.frame_len;
        idx_reg       <= '0;
        count_reg     <= '0;
        first_pos_reg <= '0;
        found_reg     <= 1'b0;
      end else if (consume) begin
        idx_reg <= idx_reg + CNT_W'(1);
        if (hit) begin
          if (count_reg != '1) count_reg <= count_reg + CNT_W'(1);
          if (!found_reg) begin
            first_pos_reg <= idx_reg;
            found_reg     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomised and directed bench for pattern_scan_ctrl, checked against a
// bit-list reference model of the matching rules.
module tb_pattern_scan_ctrl;
  import pattern_scan_pkg::*;

  localparam int ML = MAX_LEN_DEF;
  localparam int CW = CNT_W_DEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();

  pattern_scan_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference configuration
  logic [ML-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  bit            m_err;

  // results of the most recent modelled scan
  int r_cnt, r_first, r_consumed;
  bit r_found;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic cfg_write(input logic [ML-1:0] pat, input int len, input bit ovl);
    bus.cfg_we = 1'b1; bus.cfg_pattern = pat; bus.cfg_len = 4'(len); bus.cfg_overlap = ovl;
    tick();
    bus.cfg_we = 1'b0;
    if (len >= 1 && len <= ML) begin
      m_pat = pat; m_len = len; m_ovl = ovl; m_err = 0;
    end else begin
      m_err = 1;
    end
    check("cfg_err", bus.cfg_err, m_err);
    $display("cfg pat=%b len=%0d ovl=%0d cfg_err=%0d", pat, len, ovl, bus.cfg_err);
  endtask

  // One complete scan: start, feed bits, optional abort / in-scan cfg write, done, idle.
  task automatic scan(input int flen, input logic [255:0] stream, input bit rand_valid,
                      input int abort_at, input int cfg_during_len);
    logic [255:0] hist;
    int nbits, seg, budget;
    bit fin, v, ab, exp_match, ok, cfg_sent;
    hist = '0; nbits = 0; seg = 0; fin = 0; cfg_sent = 0;
    r_cnt = 0; r_first = 0; r_found = 0;
    budget = 4 * flen + 20;

    bus.start = 1'b1; bus.frame_len = CW'(flen);
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, flen != 0);
    check("ready_after_start", bus.bit_ready, flen != 0);
    check("done_after_start", bus.done, flen == 0);
    if (flen == 0) fin = 1;

    while (!fin) begin
      if (budget == 0) begin
        check("scan_timeout", 1, 0);
        break;
      end
      budget--;
      v  = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      ab = v && (abort_at == nbits);
      bus.bit_valid = v; bus.bit_in = stream[nbits]; bus.abort = ab;
      if (cfg_during_len >= 0 && nbits == 1 && !cfg_sent) begin
        bus.cfg_we = 1'b1; bus.cfg_len = 4'(cfg_during_len);
        bus.cfg_pattern = ~m_pat; bus.cfg_overlap = ~m_ovl;
        cfg_sent = 1;
      end
      exp_match = 0;
      if (ab) begin
        fin = 1;
      end else if (v) begin
        hist[nbits] = stream[nbits];
        nbits++;
        if (nbits - seg >= m_len) begin
          ok = 1;
          for (int k = 0; k < m_len; k++)
            if (hist[nbits-1-k] != m_pat[k]) ok = 0;
          if (ok) begin
            exp_match = 1;
            if (r_cnt < (1 << CW) - 1) r_cnt++;
            if (!r_found) begin r_first = nbits - 1; r_found = 1; end
            if (!m_ovl) seg = nbits;
          end
        end
        if (nbits == flen) fin = 1;
      end
      tick();
      idle_inputs();
      check("match", bus.match, exp_match);
      check("busy_in_scan", bus.busy, !fin);
      check("done_in_scan", bus.done, fin);
    end
    r_consumed = nbits;

    // Start and bits offered in DONE must be ignored.
    bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_once", bus.done, 0);
    check("busy_after_done", bus.busy, 0);
    check("ready_idle", bus.bit_ready, 0);
    tick();
    idle_inputs();
    check("match_idle", bus.match, 0);
    check("match_count", bus.match_count, r_cnt);
    check("found", bus.found, r_found);
    check("first_pos", bus.first_pos, r_first);
    check("cfg_err_hold", bus.cfg_err, m_err);
    $display("scan flen=%0d consumed=%0d count=%0d found=%0d first=%0d",
             flen, nbits, bus.match_count, bus.found, bus.first_pos);
  endtask

  function automatic logic [255:0] rand_stream();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] s7;
    logic [255:0] ones;
    int flen, len, ab;
    s7 = 256'b1010101;
    ones = '1;
    idle_inputs();
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.frame_len = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_pat = '0; m_len = 1; m_ovl = 1; m_err = 0;
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.bit_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_match", bus.match, 0);
    check("rst_count", bus.match_count, 0);
    check("rst_first", bus.first_pos, 0);
    check("rst_found", bus.found, 0);
    check("rst_cfg_err", bus.cfg_err, 0);

    // Overlapping 1010 over 1010101
    cfg_write(8'b1010, 4, 1);
    scan(7, s7, 0, -1, -1);
    check("ovl_count", bus.match_count, 2);
    check("ovl_first", bus.first_pos, 3);

    // Non-overlapping
    cfg_write(8'b1010, 4, 0);
    scan(7, s7, 0, -1, -1);
    check("novl_count", bus.match_count, 1);
    check("novl_first", bus.first_pos, 3);

    // Zero-length frame
    scan(0, s7, 0, -1, -1);
    check("zero_count", bus.match_count, 0);
    check("zero_found", bus.found, 0);

    // Abort alongside the 3rd bit: 101 would match there if it were consumed
    cfg_write(8'b101, 3, 1);
    scan(7, s7, 0, 2, -1);
    check("abort_consumed", r_consumed, 2);
    check("abort_count", bus.match_count, 0);

    // Illegal lengths leave config alone; a write during the scan is ignored
    cfg_write(8'hFF, 0, 0);
    cfg_write(8'hFF, 9, 0);
    scan(7, s7, 0, -1, 1);
    check("keep_cfg_count", bus.match_count, 3);
    check("keep_cfg_first", bus.first_pos, 2);
    cfg_write(8'b1, 1, 1);

    // Saturation run
    scan(255, ones, 0, -1, -1);
    check("sat_count", bus.match_count, 255);

    // Reset in the middle of a scan
    cfg_write(8'h00, 12, 0);
    bus.start = 1'b1; bus.frame_len = CW'(20);
    tick();
    bus.start = 1'b0;
    bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pat = '0; m_len = 1; m_ovl = 1; m_err = 0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_match", bus.match, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_count", bus.match_count, 0);
    check("mid_rst_cfg_err", bus.cfg_err, 0);
    tick();
    idle_inputs();
    check("mid_rst_no_done", bus.done, 0);
    check("mid_rst_no_match", bus.match, 0);
    // Default config (pattern 0, len 1, overlapping) counts zero bits
    scan(30, rand_stream(), 1, -1, -1);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 4) == 0) cfg_write(ML'($urandom), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15), 0);
      len = $urandom_range(1, ML);
      cfg_write(ML'($urandom_range(0, (1 << len) - 1)), len, 1'($urandom));
      flen = $urandom_range(1, 40);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, flen - 1) : -1;
      scan(flen, rand_stream(), 1, ab, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
